// File: rtl/seg7_pkg.sv
// Shared segment codes and small helpers for the seven-segment scan driver.
package seg7_pkg;

  // Logical active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // True when the scan index sits on the most significant digit
  function automatic logic idx_at_last(input int idx, input int n);
    return (idx == n - 1);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to seven-segment decoder; invalid codes show a dash, blank forces all off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg_code
);

  // Pure lookup, blank overrides the digit pattern
  always_comb begin
    seg_code = SEG_DASH;
    if (blank) begin
      seg_code = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg_code = SEG_0;
        4'd1:    seg_code = SEG_1;
        4'd2:    seg_code = SEG_2;
        4'd3:    seg_code = SEG_3;
        4'd4:    seg_code = SEG_4;
        4'd5:    seg_code = SEG_5;
        4'd6:    seg_code = SEG_6;
        4'd7:    seg_code = SEG_7;
        4'd8:    seg_code = SEG_8;
        4'd9:    seg_code = SEG_9;
        default: seg_code = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: frame-coherent snapshot, leading-zero
// blanking and a dark guard interval at the start of every digit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD        = 2,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    on,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int GRD_W = $clog2(GUARD + 2);

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [GRD_W-1:0]      GRD_INIT = GRD_W'(GUARD);
  localparam logic [6:0]            SEG_OFF  = {7{COMMON_ANODE}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{COMMON_ANODE}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [GRD_W-1:0]        guard_q, guard_d;
  logic [4*NUM_DIGITS-1:0] snap_bcd_q, snap_bcd_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick;
  logic                    idx_last;
  logic                    wrap;
  logic [3:0]              digit_sel;
  logic                    zero_above;
  logic                    blank_sel;
  logic [6:0]              seg_code;
  logic [NUM_DIGITS-1:0]   an_onehot;

  // Slot timing, scan index, guard countdown and input snapshot
  always_comb begin
    tick     = on && (cnt_q == CNT_LAST);
    idx_last = idx_at_last(int'(idx_q), NUM_DIGITS);
    wrap     = tick && idx_last;

    cnt_d = cnt_q;
    if (tick)    cnt_d = '0;
    else if (on) cnt_d = cnt_q + 1'b1;

    idx_d = idx_q;
    if (tick) idx_d = idx_last ? '0 : idx_q + 1'b1;

    guard_d = guard_q;
    if (!on || tick)          guard_d = GRD_INIT;
    else if (guard_q != '0)   guard_d = guard_q - 1'b1;

    // Disabled display tracks the input live; enabled display only at frame wrap
    snap_bcd_d = snap_bcd_q;
    snap_dp_d  = snap_dp_q;
    if (!on || wrap) begin
      snap_bcd_d = bcd_in;
      snap_dp_d  = dp_in;
    end

    frame_tick_d = wrap;
  end

  // Digit select and leading-zero detection for the current slot
  always_comb begin
    digit_sel  = snap_bcd_q[{idx_q, 2'b00} +: 4];
    zero_above = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_q) && (snap_bcd_q[4*i +: 4] != 4'd0)) zero_above = 1'b0;
    end
    blank_sel = blank_lz && zero_above && (idx_q != '0);
  end

  seg7_decode u_decode (
    .bcd      (digit_sel),
    .blank    (blank_sel),
    .seg_code (seg_code)
  );

  // Pin-level output values, darkened while disabled or inside the guard
  always_comb begin
    an_onehot        = '0;
    an_onehot[idx_q] = 1'b1;
    seg_d = on ? (seg_code ^ SEG_OFF) : SEG_OFF;
    dp_d  = on ? (snap_dp_q[idx_q] ^ COMMON_ANODE) : COMMON_ANODE;
    an_d  = (on && (guard_q == '0)) ? (an_onehot ^ AN_OFF) : AN_OFF;
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      guard_q      <= GRD_INIT;
      snap_bcd_q   <= '0;
      snap_dp_q    <= '0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= COMMON_ANODE;
      an_q         <= AN_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      guard_q      <= guard_d;
      snap_bcd_q   <= snap_bcd_d;
      snap_dp_q    <= snap_dp_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: common-anode and common-cathode instances share
// stimulus; a slot-level reference model feeds a queue drained by a monitor.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int GD = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         on;
  logic [15:0]  bcd_in;
  logic [3:0]   dp_in;
  logic         blank_lz;

  logic [6:0]   seg1, seg0;
  logic         dp1, dp0;
  logic [3:0]   an1, an0;
  logic         ft1, ft0;

  int checks   = 0;
  int failures = 0;

  // Expected logical (active-high) outputs {an[3:0], seg[6:0], dp, frame_tick}
  logic [12:0]  sbq[$];

  // Reference model state: position in the scan, not the RTL's encoding
  int m_cnt, m_idx, m_age;
  int snap_d[N];
  bit snap_p[N];
  logic [6:0] seg_tab[16];

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(GD), .COMMON_ANODE(1'b1)) dut_ca (
    .clk(clk), .reset(reset), .on(on), .bcd_in(bcd_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg(seg1), .dp(dp1), .an(an1), .frame_tick(ft1)
  );

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(GD), .COMMON_ANODE(1'b0)) dut_cc (
    .clk(clk), .reset(reset), .on(on), .bcd_in(bcd_in), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic take_snapshot();
    for (int k = 0; k < N; k++) begin
      snap_d[k] = int'(bcd_in[4*k +: 4]);
      snap_p[k] = dp_in[k];
    end
  endtask

  // Blank digit k when enabled, k is not the units digit and k..top are all zero
  function automatic bit lz_blank(input int k);
    if (!blank_lz || k == 0) return 1'b0;
    for (int j = k; j < N; j++) if (snap_d[j] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: predict what the outputs show after this edge, then advance the model
  task automatic step();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed, ef;
    ea = '0; es = '0; ed = 1'b0; ef = 1'b0;
    if (!reset) begin
      m_cnt = 0; m_idx = 0; m_age = 0;
      for (int k = 0; k < N; k++) begin snap_d[k] = 0; snap_p[k] = 1'b0; end
    end else if (on) begin
      if (m_age >= GD) ea[m_idx] = 1'b1;
      es = lz_blank(m_idx) ? 7'h00 : seg_tab[snap_d[m_idx]];
      ed = snap_p[m_idx];
      ef = (m_cnt == RD - 1) && (m_idx == N - 1);
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_age = 0;
        if (m_idx == N - 1) begin
          m_idx = 0;
          take_snapshot();
        end else begin
          m_idx++;
        end
      end else begin
        m_cnt++;
        m_age++;
      end
    end else begin
      take_snapshot();
      m_age = 0;
    end
    @(posedge clk);
    #1;
    sbq.push_back({ea, es, ed, ef});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every edge presents a fresh output word; compare both polarities
  always @(negedge clk) begin : mon
    logic [12:0] e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({an1, seg1, dp1, ft1} !== (e ^ 13'h1FFE)) begin
        failures++;
        $display("FAIL sb_common_anode actual=%h required=%h", {an1, seg1, dp1, ft1}, e ^ 13'h1FFE);
      end
      checks++;
      if ({an0, seg0, dp0, ft0} !== e) begin
        failures++;
        $display("FAIL sb_common_cathode actual=%h required=%h", {an0, seg0, dp0, ft0}, e);
      end
    end
  end

  initial begin
    logic [3:0] an_tab[4];
    logic [6:0] sg_tab[4];
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sg_tab  = '{7'h19, 7'h30, 7'h24, 7'h79};

    reset = 1'b0; on = 1'b0; bcd_in = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;
    run(3);
    chk("reset_an",   32'(an1),  32'hF);
    chk("reset_seg",  32'(seg1), 32'h7F);
    chk("reset_dp",   32'(dp1),  32'h1);
    chk("reset_ft",   32'(ft1),  32'h0);
    chk("reset_an_cc", 32'(an0), 32'h0);

    // Release with display disabled
    reset = 1'b1; bcd_in = 16'h1234;
    run(3);
    chk("idle_an", 32'(an1), 32'hF);

    // Basic scan with fixed expectations
    on = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("basic_an",  32'(an1),  32'((i % 4 == 0) ? 4'hF : an_tab[i / 4]));
      chk("basic_seg", 32'(seg1), 32'(sg_tab[i / 4]));
      chk("basic_ft",  32'(ft1),  32'(i == 15));
      if (i == 1) begin
        chk("cc_an_d0",  32'(an0),  32'h1);
        chk("cc_seg_d0", 32'(seg0), 32'h66);
      end
    end

    // Leading-zero blanking on and off
    bcd_in = 16'h0050; blank_lz = 1'b1;
    run(2 * 16 + 3);
    blank_lz = 1'b0;
    run(16);

    // Invalid code and decimal point
    bcd_in = 16'h00A0; dp_in = 4'b0010;
    run(2 * 16);

    // Frame coherence: change input mid-frame
    bcd_in = 16'h1111; dp_in = 4'h0;
    run(2 * 16);
    for (int g = 0; g < 64 && !(m_idx == 1 && m_cnt == 1); g++) step();
    bcd_in = 16'h2222;
    run(26);

    // Drop enable mid-slot at digit 2, then resume
    for (int g = 0; g < 64 && !(m_idx == 2 && m_cnt == 1); g++) step();
    on = 1'b0;
    run(5);
    on = 1'b1;
    run(20);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_an",    32'(an1),  32'hF);
    chk("async_seg",   32'(seg1), 32'h7F);
    chk("async_an_cc", 32'(an0),  32'h0);
    run(2);
    reset = 1'b1;
    run(20);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      on = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < N; k++)
          bcd_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp_in = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      step();
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
